// File: rtl/muldiv_if.sv
// Handshake bundle between execute stage and the iterative mul/div sequencer.
// Master issues M-extension ops; slave reports busy/done/result.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, a, b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, a, b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M mul/div sequencer: 32-step shift-add / restoring divide.
// Optional MULDIV_FASTPATH_EN short-circuits div-by-zero, overflow, mul-by-zero.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, PREP, ITER, FIX, DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  state_t state_q, state_d;

  logic [2:0]        op;
  logic [XLEN-1:0]   ar, br, dv;
  logic [2*XLEN-1:0] acc;
  logic              neg_q, neg_r;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   res_q;
  logic              busy_q, done_q;

  logic              is_div;
  logic              a_sgn, b_sgn;
  logic              sa, sb;
  logic [XLEN-1:0]   ua, ub;
  logic [XLEN:0]     madd;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     rem33;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] div_nxt;
  logic [2*XLEN-1:0] prod_neg;
  logic [XLEN-1:0]   hi, quo, rmd;
  logic [XLEN-1:0]   fix_res;
  logic              fast_hit;
  logic [XLEN-1:0]   fast_res;

  assign is_div = op[2];
  assign a_sgn  = (op == 3'b001) || (op == 3'b010)
               || (op == 3'b100) || (op == 3'b110);
  assign b_sgn  = (op == 3'b001) || (op == 3'b100)
               || (op == 3'b110);
  assign sa     = a_sgn & ar[XLEN-1];
  assign sb     = b_sgn & br[XLEN-1];
  assign ua     = sa ? -ar : ar;
  assign ub     = sb ? -br : br;

  assign madd    = {1'b0, acc[2*XLEN-1:XLEN]}
                 + (acc[0] ? {1'b0, dv} : '0);
  assign mul_nxt = {madd, acc[XLEN-1:1]};

  // Remainder after the left shift can need XLEN+1 bits.
  assign rem33   = acc[2*XLEN-1:XLEN-1];
  assign diff    = {1'b0, rem33} - {2'b00, dv};
  assign div_nxt = diff[XLEN+1]
                 ? {acc[2*XLEN-2:0], 1'b0}
                 : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  assign prod_neg = -acc;
  assign hi  = neg_q ? prod_neg[2*XLEN-1:XLEN]
                     : acc[2*XLEN-1:XLEN];
  assign quo = (neg_q && br != '0) ? -acc[XLEN-1:0]
                                   : acc[XLEN-1:0];
  assign rmd = neg_r ? -acc[2*XLEN-1:XLEN]
                     : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    unique case (1'b1)
      (op == 3'b000):             fix_res = acc[XLEN-1:0];
      (!op[2] && op[1:0] != 0):   fix_res = hi;
      (op[2] && !op[1]):          fix_res = quo;
      (op[2] && op[1]):           fix_res = rmd;
      default:                    fix_res = '0;
    endcase
  end

`ifdef MULDIV_FASTPATH_EN
  logic ovf;
  assign ovf = (op == 3'b100 || op == 3'b110)
            && ar == {1'b1, {(XLEN-1){1'b0}}}
            && br == '1;

  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
    unique case (1'b1)
      (is_div && br == '0): begin
        fast_hit = 1'b1;
        fast_res = op[1] ? ar : '1;
      end
      (is_div && br != '0 && ovf): begin
        fast_hit = 1'b1;
        fast_res = op[1] ? '0 : ar;
      end
      (!is_div && (ar == '0 || br == '0)): begin
        fast_hit = 1'b1;
        fast_res = '0;
      end
      default: ;
    endcase
  end
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = PREP;
      PREP: state_d = fast_hit ? DONE : ITER;
      ITER: if (cnt == LAST) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op    <= '0;
      ar    <= '0;
      br    <= '0;
      dv    <= '0;
      acc   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
      res_q <= '0;
    end else if (!bus.flush) begin
      unique case (state_q)
        IDLE: if (bus.start) begin
          op <= bus.funct3;
          ar <= bus.a;
          br <= bus.b;
        end
        PREP: begin
          neg_q <= sa ^ sb;
          neg_r <= sa;
          acc   <= {{XLEN{1'b0}}, ua};
          dv    <= ub;
          cnt   <= '0;
          if (fast_hit) res_q <= fast_res;
        end
        ITER: begin
          acc <= is_div ? div_nxt : mul_nxt;
          if (cnt != LAST) cnt <= cnt + CNT_W'(1);
        end
        FIX:  res_q <= fix_res;
        default: ;
      endcase
    end
  end

  // Status is registered, so done lands one edge after the DONE state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= !bus.flush && (state_q != IDLE || bus.start);
      done_q <= !bus.flush && state_q == DONE;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table plus flush/reset/start-ignore
// sequences; latency expectation follows MULDIV_FASTPATH_EN.
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;

  muldiv_if bus ();

  muldiv_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef MULDIV_FASTPATH_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        fast;
  } vec_t;

  vec_t tv [17];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name,
                        input logic [2:0] f,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic fast,
                        input logic [31:0] exp,
                        input bit poke);
    int   lat;
    int   exp_lat;
    logic busy_ok;
    logic seen;
    exp_lat = (fast && FP) ? 2 : 35;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.a      = x;
    bus.b      = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      bus.start = poke && lat == 5;
      if (poke && lat == 5) begin
        bus.funct3 = 3'b100;
        bus.a = 32'd5;
        bus.b = 32'd0;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk({name, " result"}, bus.result, exp);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " busy span"}, {31'b0, busy_ok}, 32'd1);
    @(posedge clk);
    #1;
    chk({name, " idle after"}, {30'b0, bus.busy, bus.done}, 32'd0);
  endtask

  initial begin
    logic seen;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'b000;
    bus.a      = '0;
    bus.b      = '0;

    tv[0]  = '{3'b000, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    tv[1]  = '{3'b001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    tv[2]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0};
    tv[3]  = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0};
    tv[4]  = '{3'b100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 1'b0};
    tv[5]  = '{3'b110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 1'b0};
    tv[6]  = '{3'b101, 32'hFFFFFFF9, 32'h2,        32'h7FFFFFFC, 1'b0};
    tv[7]  = '{3'b111, 32'hFFFFFFF9, 32'h2,        32'h00000001, 1'b0};
    tv[8]  = '{3'b100, 32'h5,        32'h0,        32'hFFFFFFFF, 1'b1};
    tv[9]  = '{3'b110, 32'h5,        32'h0,        32'h00000005, 1'b1};
    tv[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    tv[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    tv[12] = '{3'b101, 32'h5,        32'h0,        32'hFFFFFFFF, 1'b1};
    tv[13] = '{3'b111, 32'h5,        32'h0,        32'h00000005, 1'b1};
    tv[14] = '{3'b110, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 1'b1};
    tv[15] = '{3'b000, 32'h0,        32'h1234,     32'h00000000, 1'b1};
    tv[16] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};

    #12;
    chk("reset status", {30'b0, bus.busy, bus.done}, 32'd0);
    chk("reset result", bus.result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      run_op($sformatf("vec%0d", i), tv[i].f, tv[i].a, tv[i].b,
             tv[i].fast, tv[i].exp, 1'b0);
    end

    run_op("start_ignored", 3'b000, 32'h7, 32'hFFFFFFFD,
           1'b0, 32'hFFFFFFEB, 1'b1);

    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'b101;
    bus.a      = 32'd1000;
    bus.b      = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush status", {30'b0, bus.busy, bus.done}, 32'd0);
    chk("flush result", bus.result, 32'hFFFFFFEB);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("flush no done", {31'b0, seen}, 32'd0);

    run_op("after_flush", 3'b101, 32'd1000, 32'd3,
           1'b0, 32'd333, 1'b0);

    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'b101;
    bus.a      = 32'd1000;
    bus.b      = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async reset status", {30'b0, bus.busy, bus.done}, 32'd0);
    chk("async reset result", bus.result, 32'd0);
    #2;
    reset = 1'b0;

    run_op("after_reset", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF,
           1'b0, 32'hFFFFFFFE, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer for the pipelined core's execute stage.
- Accepts one M-extension op, sequences a 32-step shift-add (MUL*) or restoring shift-subtract (DIV*/REM*) loop over a single 64-bit accumulator plus a 33-bit add/sub, then applies sign fix-up.
- Stalls the pipeline via busy; returns a registered 32-bit result with a one-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width; 2**CNT_W must equal XLEN.

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  32  rs1 operand, sampled on accept
- b  input  32  rs2 operand, sampled on accept
- flush  input  1  pipeline kill; aborts the op in flight
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; result valid in that cycle
- result  output  32  registered result, held until the next accepted start

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, result=0, counter=0, accumulator=0.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE: when start=1 at edge N, latch funct3, a, b and go to PREP. Otherwise stay.
- PREP, 1 cycle:
  - Signed ops take absolute values and record neg_q = sa^sb and neg_r = sa.
  - Sign handling: MULHSU treats only a as signed; MULHU/DIVU/REMU treat both unsigned.
  - Load the accumulator; counter=0; go to ITER.
- ITER, exactly 32 cycles, counter 0..31:
  - MUL*: if acc[0], add the multiplicand to acc[63:32] with the 33-bit carry, then shift right 1.
  - DIV*/REM*: shift left 1; trial-subtract the divisor from the upper 33 bits; if the result is non-negative, keep it and set quotient bit 1, else restore.
  - Go to FIX when counter==31. The counter does not wrap past 31.
- FIX, 1 cycle, selects and sign-corrects:
  - MUL returns the low 32 bits of the product.
  - MULH/MULHSU/MULHU return the high 32 bits, with the 64-bit two's-complement negate applied if neg_q.
  - Quotient is negated if neg_q and b!=0.
  - Remainder is negated if neg_r.
  - Writes result; go to DONE.
- DONE, 1 cycle: done=1, busy=1; next state IDLE. busy=0 in the following cycle.
- Latency: start at edge N gives done=1 in the cycle after edge N+35. Back-to-back start is allowed in the first IDLE cycle.
- Division by zero, from the algorithm plus the FIX rule:
  - DIV/DIVU return 0xFFFFFFFF.
  - REM/REMU return a.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000; REM returns 0.
- start while busy: ignored; no queuing.
- flush=1 in any non-IDLE state: next edge goes to IDLE, no done, result unchanged.
- flush has priority over state progression. flush and start together in IDLE: start is ignored.
- Reset mid-operation: immediate async return to reset values.

Optional Feature:
- Macro MULDIV_FASTPATH_EN.
- Defined: PREP detects the special cases and goes directly to DONE, writing result in PREP, so done is high in the cycle after edge N+2.
  - b==0 for DIV*/REM* writes the div-by-zero results above.
  - DIV/REM with a=0x80000000 and b=0xFFFFFFFF writes 0x80000000 / 0.
  - Any MUL* with a==0 or b==0 writes 0.
- Undefined: every op takes the full 35-edge latency, with identical result values.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD): result 0xFFFFFFEB. done in the cycle after edge N+35; busy=1 for cycles N+1..N+35.
- MULH / MULHSU / MULHU with a=0x80000000, b=0xFFFFFFFF: results 0x00000000 / 0x80000000 / 0x7FFFFFFF.
- DIV a=-7, b=2: result 0xFFFFFFFD. REM: 0xFFFFFFFF. DIVU 0xFFFFFFF9/2: 0x7FFFFFFC. REMU: 1.
- DIV a=5, b=0: result 0xFFFFFFFF. REM: 5. DIV 0x80000000 / 0xFFFFFFFF: 0x80000000. Run with and without MULDIV_FASTPATH_EN; check latency 2 vs 35.
- flush at ITER cycle 10: IDLE next edge, no done, result holds its prior value. A new start then completes normally. start pulsed mid-op is ignored.
- reset asserted asynchronously mid-ITER: busy, done and result go to 0 immediately, before the next clk edge.
